// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_if
// Brief    : Request/response bundle between execute-stage control and divider.
// Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [1:0]      DivOp;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Flush;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output Start, DivOp, A, B, Flush,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, DivOp, A, B, Flush,
    output Busy, Done, Result
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  div_unit_if.slave   bus
);

  localparam int              c_CNT_W = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [XLEN-1:0] c_ONE   = XLEN'(1);
  localparam logic [XLEN-1:0] c_MSB   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_div;
  logic                r_is_rem;
  logic                r_qneg;
  logic                r_rneg;

  logic                w_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_bzero;
  logic                w_ovf;
  logic [XLEN:0]       w_rem_shift;
  logic [XLEN:0]       w_diff;
  logic                w_ok;
  logic [XLEN-1:0]     w_rem_next;
  logic [XLEN-1:0]     w_quo_next;
  logic [XLEN-1:0]     w_q_fin;
  logic [XLEN-1:0]     w_r_fin;

  // DivOp[0] clear selects the signed forms, DivOp[1] selects remainder.
  assign w_signed = ~bus.DivOp[0];
  assign w_a_neg  = w_signed & bus.A[XLEN-1];
  assign w_b_neg  = w_signed & bus.B[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~bus.A + c_ONE) : bus.A;
  assign w_b_mag  = w_b_neg ? (~bus.B + c_ONE) : bus.B;
  assign w_bzero  = (bus.B == '0);
  assign w_ovf    = w_signed && (bus.A == c_MSB) && (bus.B == '1);

  // One restoring step; the extra top bit of the trial difference is the borrow.
  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_div};
  assign w_ok        = ~w_diff[XLEN];
  assign w_rem_next  = w_ok ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
  assign w_quo_next  = {r_quo[XLEN-2:0], w_ok};
  assign w_q_fin     = r_qneg ? (~w_quo_next + c_ONE) : w_quo_next;
  assign w_r_fin     = r_rneg ? (~w_rem_next + c_ONE) : w_rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_is_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
    end else if (bus.Flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            if (w_bzero || w_ovf) begin
              if (w_bzero)
                r_result <= bus.DivOp[1] ? bus.A : '1;
              else
                r_result <= bus.DivOp[1] ? '0 : bus.A;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_quo    <= w_a_mag;
              r_div    <= w_b_mag;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_is_rem <= bus.DivOp[1];
              r_qneg   <= w_signed & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
              r_rneg   <= w_signed & bus.A[XLEN-1];
              r_state  <= S_CALC;
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_LAST) begin
            r_result <= r_is_rem ? w_r_fin : w_q_fin;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.Result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed and random checks of div_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int XLEN = 32;
  localparam logic [1:0] c_DIV = 2'b00, c_DIVU = 2'b01, c_REM = 2'b10, c_REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;
  logic [XLEN-1:0] last_res;

  div_unit_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] q, r;
    if (b == 0) begin
      q = '1; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  // Issue one op; Done must appear exactly at the model latency with the model result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b);
    logic [XLEN-1:0] exp;
    int exp_lat, k, nbusy;
    exp     = ref_model(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    bus.Start = 1'b1; bus.DivOp = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    k = 1; nbusy = 0;
    while (!bus.Done && k <= 40) begin
      if (bus.Busy) nbusy++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy"}, 32'(nbusy), 32'(exp_lat - 1));
    check({tag, "_res"}, bus.Result, exp);
    last_res = exp;
  endtask

  initial begin
    int k, ndone;
    logic [1:0] op;
    logic [XLEN-1:0] a, b;
    n_cmp = 0; n_mis = 0; last_res = '0;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.DivOp = 2'b00; bus.A = '0; bus.B = '0; bus.Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_res", bus.Result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7", c_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    check("done_falls", 32'(bus.Done), 32'd0);
    check("res_held", bus.Result, 32'd14);
    run_op("remu_100_7", c_REMU, 32'd100, 32'd7);
    run_op("div_m7_2", c_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", c_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_5_0", c_DIVU, 32'd5, 32'd0);
    run_op("rem_5_0", c_REM, 32'd5, 32'd0);
    run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", c_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_ovf_pat", c_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // Back-to-back: new Start accepted in the DONE cycle.
    run_op("b2b_first", c_DIVU, 32'd1000, 32'd10);
    run_op("b2b_second", c_DIVU, 32'd9, 32'd3);

    // Flush mid-calculation.
    @(negedge clk);
    bus.Start = 1'b1; bus.DivOp = c_DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1; bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.Flush = 1'b1;
    @(posedge clk); #1; bus.Flush = 1'b0;
    check("flush_busy", 32'(bus.Busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done) ndone++;
      @(posedge clk); #1;
    end
    check("flush_nodone", 32'(ndone), 32'd0);
    check("flush_res", bus.Result, last_res);

    // Flush beats a simultaneous Start.
    @(negedge clk);
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.DivOp = c_DIVU; bus.A = 32'd50; bus.B = 32'd5;
    @(posedge clk); #1; bus.Start = 1'b0; bus.Flush = 1'b0;
    check("flushwin_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk); #1;
    check("flushwin_done", 32'(bus.Done), 32'd0);

    // Start pulse during CALC must not disturb the running op.
    @(negedge clk);
    bus.Start = 1'b1; bus.DivOp = c_DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1; bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b1; bus.DivOp = c_REMU; bus.A = 32'd9; bus.B = 32'd0;
    @(posedge clk); #1; bus.Start = 1'b0;
    k = 6;
    while (!bus.Done && k <= 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("ign_lat", 32'(k), 32'd33);
    check("ign_res", bus.Result, 32'd14);
    ndone = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (bus.Done) ndone++;
    end
    check("ign_nodone", 32'(ndone), 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.Start = 1'b1; bus.DivOp = c_DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1; bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.Busy), 32'd0);
    check("arst_done", 32'(bus.Done), 32'd0);
    check("arst_res", bus.Result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", 32'(bus.Busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
